// File: rtl/imem_boot_loader.sv
// imem_boot_loader: splits a 32-bit word stream into big-endian byte writes while holding the core in reset; LOADER_CHECKSUM_EN enables the checksum accumulator
module imem_boot_loader #(
  parameter int WORD_W   = 32,
  parameter int CELL_W   = 8,
  parameter int MEM_SIZE = 256,
  parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CELL_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] checksum
);
  typedef enum logic [2:0] {IDLE, CHECK, WAIT_WORD, WRITE, FINISH} state_t;
  state_t state, state_nx;
  logic [ADDR_W:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic [WORD_W-1:0] shift;
  logic [1:0] byte_idx;
  logic err_r;
  logic range_bad;
  assign range_bad = (addr + (ADDR_W+1)'(3)) > (ADDR_W+1)'(MEM_SIZE - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      shift     <= '0;
      byte_idx  <= '0;
      err_r     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        addr      <= {1'b0, base_addr};
        remaining <= word_count;
        err_r     <= 1'b0;
      end
      if (state == CHECK) err_r <= (remaining != '0) && range_bad;
      if (state == WAIT_WORD && in_valid) begin
        shift    <= in_data;
        byte_idx <= '0;
      end
      if (state == WRITE) begin
        shift    <= shift << CELL_W;
        addr     <= addr + 1'b1;
        byte_idx <= byte_idx + 1'b1;
        if (byte_idx == 2'd3) remaining <= remaining - 1'b1;
      end
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
  always_ff @(posedge clk) begin
    if (rst) sum <= '0;
    else if (state == IDLE && start) sum <= '0;
    else if (state == WAIT_WORD && in_valid) sum <= sum + in_data;
  end
  assign checksum = sum;
`else
  assign checksum = '0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = start ? CHECK : IDLE;
      CHECK:     state_nx = (remaining == '0 || range_bad) ? FINISH : WAIT_WORD;
      WAIT_WORD: state_nx = in_valid ? WRITE : WAIT_WORD;
      WRITE:     state_nx = (byte_idx == 2'd3) ? CHECK : WRITE;
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    in_ready  = state == WAIT_WORD;
    mem_we    = state == WRITE;
    mem_addr  = mem_we ? addr[ADDR_W-1:0] : '0;
    mem_wdata = mem_we ? shift[WORD_W-1 -: CELL_W] : '0;
    busy      = state != IDLE;
    cpu_hold  = busy;
    done      = state == FINISH;
    err       = done && err_r;
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench checking byte writes, completion pulses and checksum
module tb_imem_boot_loader;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [7:0] base_addr = 0;
  logic [7:0] word_count = 0;
  logic in_valid = 0;
  logic [31:0] in_data = 0;
  logic in_ready, mem_we, cpu_hold, busy, done, err;
  logic [7:0] mem_addr, mem_wdata;
  logic [31:0] checksum;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {logic [7:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic e; logic [31:0] ck;} dn_t;
  wr_t wq[$];
  dn_t dq[$];
  wr_t w_exp;
  dn_t d_exp;
  imem_boot_loader #(.WORD_W(32), .CELL_W(8), .MEM_SIZE(256)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .err(err), .checksum(checksum)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] ck(input logic [31:0] v);
`ifdef LOADER_CHECKSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction
  always @(negedge clk) begin
    if (mem_we) begin
      chk("write_expected", wq.size() != 0, 1);
      chk("hold_during_write", cpu_hold, 1);
      if (wq.size() != 0) begin
        w_exp = wq.pop_front();
        chk("waddr", mem_addr, w_exp.a);
        chk("wdata", mem_wdata, w_exp.d);
      end
    end
    if (done) begin
      chk("done_expected", dq.size() != 0, 1);
      if (dq.size() != 0) begin
        d_exp = dq.pop_front();
        chk("err", err, d_exp.e);
        chk("checksum", checksum, d_exp.ck);
      end
    end
  end
  task automatic push_word(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) wq.push_back('{a: a + 8'(i), d: w[31 - 8*i -: 8]});
  endtask
  task automatic do_start(input logic [7:0] b, input logic [7:0] c);
    @(posedge clk); #1;
    start = 1; base_addr = b; word_count = c;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic send_word(input logic [31:0] w, input bit toggle);
    bit hs = 0;
    in_data = w;
    for (int i = 0; i < 60 && !hs; i++) begin
      in_valid = toggle ? i[0] : 1'b1;
      hs = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("handshake", hs, 1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("idle_reached", busy, 0);
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_outs"}, {in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err}, 0);
    chk({name, "_checksum"}, checksum, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 0;
    push_word(8'd0, 32'h8020000A);
    push_word(8'd4, 32'h8040000F);
    dq.push_back('{e: 1'b0, ck: ck(32'h00600019)});
    do_start(8'd0, 8'd2);
    @(posedge clk); #1;
    chk("basic_hold", cpu_hold, 1);
    send_word(32'h8020000A, 0);
    send_word(32'h8040000F, 0);
    wait_idle();
    chk("basic_sum_held", checksum, ck(32'h00600019));
    push_word(8'd64, 32'h01020304);
    push_word(8'd68, 32'hA5A55A5A);
    push_word(8'd72, 32'hDEADBEEF);
    dq.push_back('{e: 1'b0, ck: ck(32'h01020304 + 32'hA5A55A5A + 32'hDEADBEEF)});
    do_start(8'd64, 8'd3);
    send_word(32'h01020304, 1);
    send_word(32'hA5A55A5A, 1);
    send_word(32'hDEADBEEF, 1);
    wait_idle();
    dq.push_back('{e: 1'b0, ck: 32'h0});
    do_start(8'd10, 8'd0);
    @(posedge clk); #1;
    chk("zero_done_lat", done, 1);
    wait_idle();
    push_word(8'd252, 32'h11223344);
    dq.push_back('{e: 1'b1, ck: ck(32'h11223344)});
    do_start(8'd252, 8'd2);
    send_word(32'h11223344, 0);
    wait_idle();
    wq.push_back('{a: 8'd16, d: 8'hA1});
    wq.push_back('{a: 8'd17, d: 8'hB2});
    do_start(8'd16, 8'd1);
    send_word(32'hA1B2C3D4, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk_zero("midreset");
    rst = 0;
    push_word(8'd32, 32'hFFFFFFFF);
    push_word(8'd36, 32'h00000002);
    dq.push_back('{e: 1'b0, ck: ck(32'h00000001)});
    do_start(8'd32, 8'd2);
    send_word(32'hFFFFFFFF, 0);
    send_word(32'h00000002, 0);
    wait_idle();
    chk("wrap_sum_held", checksum, ck(32'h00000001));
    repeat (3) @(posedge clk);
    #1;
    chk("writes_left", wq.size(), 0);
    chk("dones_left", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
